pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_stage.sv | 136 +++++++++++++
 tb/tb_pipe_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
//   One pipeline stage with valid/ready handshakes, flush and a bubble counter.
//   All state updates happen on the falling edge of clk.
//
//   SKID = 1 : main register (drives the outputs) plus one skid register.
//              in_ready depends only on registers, which breaks the ready path.
//   SKID = 0 : single main register. in_ready is combinational from out_ready.
//
// Ports
//   clk         stage clock (falling-edge active)
//   rst_n       asynchronous active-low reset
//   in_valid    upstream entry valid
//   in_ready    stage can accept an entry (0 while in reset)
//   in_ctrl     upstream control field  [CTRL_W]
//   in_data     upstream payload        [DATA_W]
//   out_valid   output entry valid (registered)
//   out_ready   downstream accepts an entry
//   out_ctrl    output control field, zero while out_valid=0 (registered)
//   out_data    output payload, zero while out_valid=0 (registered)
//   flush       discard every held entry and any same-edge input entry
//   bubble_cnt  saturating count of edges with out_ready=1 and out_valid=0
// -----------------------------------------------------------------------------
module pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Control and payload travel together so they can never be updated apart.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q;

  logic   in_xfer;
  logic   out_xfer;
  entry_t in_entry;

  // The skid variant's ready comes from a register only; the plain register
  // variant may take a new entry on the same edge the held one leaves.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = rst_n && !skid_valid_q;
    end else begin : g_reg_ready
      assign in_ready = rst_n && (!main_valid_q || out_ready);
    end
  endgenerate

  assign in_xfer       = in_valid && in_ready && !flush;
  assign out_xfer      = main_valid_q && out_ready;
  assign in_entry.ctrl = in_ctrl;
  assign in_entry.data = in_data;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (flush) begin
      main_d       = '0;
      main_valid_d = 1'b0;
      skid_d       = '0;
      skid_valid_d = 1'b0;
    end else if (out_xfer || !main_valid_q) begin
      // Main is free this edge: refill from skid first to keep arrival order.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        // Clear the payload too, so a bubble never shows stale control bits.
        main_d       = '0;
        main_valid_d = 1'b0;
      end
    end else if (in_xfer && (SKID != 0)) begin
      // Main is stalled: park the new entry in skid.
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      // A starved downstream cycle counts even on a flush edge.
      if (out_ready && !main_valid_q && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid  = main_valid_q;
  assign out_ctrl   = main_q.ctrl;
  assign out_data   = main_q.data;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage
//   Three stages share one stimulus stream:
//     u_skid : SKID=1, CNT_W=16
//     u_reg  : SKID=0, CNT_W=16
//     u_cnt  : SKID=1, CNT_W=3 (bubble counter saturation)
//   The reference model treats each stage as a FIFO (capacity 2 for the skid
//   variant, capacity 1 for the register variant) plus saturating counters.
// -----------------------------------------------------------------------------
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  logic        s_ready, s_valid, r_ready, r_valid, c_ready, c_valid;
  logic [7:0]  s_ctrl, r_ctrl, c_ctrl;
  logic [31:0] s_data, r_data, c_data;
  logic [15:0] s_cnt, r_cnt;
  logic [2:0]  c_cnt;

  always #5 clk = ~clk;

  pipe_stage #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_valid),
    .out_ready(out_ready), .out_ctrl(s_ctrl), .out_data(s_data),
    .flush(flush), .bubble_cnt(s_cnt));

  pipe_stage #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_reg (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(r_valid),
    .out_ready(out_ready), .out_ctrl(r_ctrl), .out_data(r_data),
    .flush(flush), .bubble_cnt(r_cnt));

  pipe_stage #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(3)) u_cnt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_valid),
    .out_ready(out_ready), .out_ctrl(c_ctrl), .out_data(c_data),
    .flush(flush), .bubble_cnt(c_cnt));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [39:0] q2[$];   // skid variant: FIFO of {ctrl,data}, depth 2
  logic [39:0] q1[$];   // register variant: depth 1
  int cnt_s = 0;
  int cnt_r = 0;
  int cnt_c = 0;

  typedef struct {
    bit          iv;
    logic [7:0]  ic;
    logic [31:0] id;
    bit          ordy;
    bit          fl;
    bit          ev;
    logic [7:0]  ec;
    logic [31:0] ed;
    bit          er;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit iv, logic [7:0] ic, logic [31:0] id, bit ordy,
                              bit fl, bit ev, logic [7:0] ec, logic [31:0] ed,
                              bit er);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ec = ec; v.ed = ed; v.er = er;
    return v;
  endfunction

  // Compare all DUT outputs against the model state (between edges).
  task automatic check_outputs();
    logic [39:0] h2, h1;
    h2 = (q2.size() > 0) ? q2[0] : 40'h0;
    h1 = (q1.size() > 0) ? q1[0] : 40'h0;
    check("skid in_ready", s_ready, q2.size() < 2);
    check("skid out_valid", s_valid, q2.size() > 0);
    check("skid out_ctrl", s_ctrl, h2[39:32]);
    check("skid out_data", s_data, h2[31:0]);
    check("skid bubble_cnt", s_cnt, cnt_s);
    check("reg in_ready", r_ready, (q1.size() == 0) || out_ready);
    check("reg out_valid", r_valid, q1.size() > 0);
    check("reg out_ctrl", r_ctrl, h1[39:32]);
    check("reg out_data", r_data, h1[31:0]);
    check("reg bubble_cnt", r_cnt, cnt_r);
    check("cnt in_ready", c_ready, q2.size() < 2);
    check("cnt out_valid", c_valid, q2.size() > 0);
    check("cnt bubble_cnt", c_cnt, cnt_c);
  endtask

  // One cycle: drive inputs after the rising edge, compare, advance the model,
  // then let the falling edge update the DUTs.
  task automatic step(input bit iv, input logic [7:0] ic, input logic [31:0] id,
                      input bit ordy, input bit fl);
    bit rdy2, rdy1;
    @(posedge clk);
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    rdy2 = q2.size() < 2;
    rdy1 = (q1.size() == 0) || ordy;
    if (ordy && q2.size() == 0) begin
      cnt_s = (cnt_s < 65535) ? cnt_s + 1 : cnt_s;
      cnt_c = (cnt_c < 7) ? cnt_c + 1 : cnt_c;
    end
    if (ordy && q1.size() == 0) cnt_r = (cnt_r < 65535) ? cnt_r + 1 : cnt_r;
    if (fl) begin
      q2.delete();
      q1.delete();
    end else begin
      if (ordy && q2.size() > 0) void'(q2.pop_front());
      if (iv && rdy2) q2.push_back({ic, id});
      if (ordy && q1.size() > 0) void'(q1.pop_front());
      if (iv && rdy1) q1.push_back({ic, id});
    end
    @(negedge clk);
  endtask

  // Reset pulse between edges; checks asynchronous clearing and release.
  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst skid out_valid", s_valid, 0);
    check("rst skid out_ctrl", s_ctrl, 0);
    check("rst skid out_data", s_data, 0);
    check("rst skid bubble_cnt", s_cnt, 0);
    check("rst skid in_ready", s_ready, 0);
    check("rst reg out_valid", r_valid, 0);
    check("rst reg out_data", r_data, 0);
    check("rst reg in_ready", r_ready, 0);
    check("rst cnt bubble_cnt", c_cnt, 0);
    check("rst cnt in_ready", c_ready, 0);
    #1;
    rst_n = 1'b1;
    #1;
    check("post-rst skid in_ready", s_ready, 1);
    check("post-rst reg in_ready", r_ready, 1);
    check("post-rst cnt in_ready", c_ready, 1);
    q2.delete();
    q1.delete();
    cnt_s = 0;
    cnt_r = 0;
    cnt_c = 0;
  endtask

  initial begin
    int pct;

    // Directed vectors for u_skid; expectations are the outputs after the edge.
    // Ordered stream with out_ready held high.
    tbl.push_back(mk(1, 8'h01, 32'hA, 1, 0,  1, 8'h01, 32'hA, 1));
    tbl.push_back(mk(1, 8'h02, 32'hB, 1, 0,  1, 8'h02, 32'hB, 1));
    tbl.push_back(mk(1, 8'h03, 32'hC, 1, 0,  1, 8'h03, 32'hC, 1));
    tbl.push_back(mk(1, 8'h04, 32'hD, 1, 0,  1, 8'h04, 32'hD, 1));
    tbl.push_back(mk(0, 8'h00, 32'h0, 1, 0,  0, 8'h00, 32'h0, 1));
    // Stall fills main then skid; release drains in order.
    tbl.push_back(mk(1, 8'h11, 32'h111, 0, 0,  1, 8'h11, 32'h111, 1));
    tbl.push_back(mk(1, 8'h22, 32'h222, 0, 0,  1, 8'h11, 32'h111, 0));
    tbl.push_back(mk(0, 8'h00, 32'h0,   1, 0,  1, 8'h22, 32'h222, 1));
    tbl.push_back(mk(0, 8'h00, 32'h0,   1, 0,  0, 8'h00, 32'h0,   1));
    // Flush with both registers full and an input offered.
    tbl.push_back(mk(1, 8'h44, 32'h444, 0, 0,  1, 8'h44, 32'h444, 1));
    tbl.push_back(mk(1, 8'h55, 32'h555, 0, 0,  1, 8'h44, 32'h444, 0));
    tbl.push_back(mk(1, 8'h33, 32'h333, 0, 1,  0, 8'h00, 32'h0,   1));
    // Flush while an accepted input and an output transfer coincide.
    tbl.push_back(mk(1, 8'h77, 32'h777, 0, 0,  1, 8'h77, 32'h777, 1));
    tbl.push_back(mk(1, 8'h33, 32'h333, 1, 1,  0, 8'h00, 32'h0,   1));
    // First edge after flush accepts normally.
    tbl.push_back(mk(1, 8'h66, 32'h666, 0, 0,  1, 8'h66, 32'h666, 1));
    tbl.push_back(mk(0, 8'h00, 32'h0,   1, 0,  0, 8'h00, 32'h0,   1));

    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].ordy, tbl[i].fl);
      #1;
      check($sformatf("vec%0d out_valid", i), s_valid, tbl[i].ev);
      check($sformatf("vec%0d out_ctrl", i), s_ctrl, tbl[i].ec);
      check($sformatf("vec%0d out_data", i), s_data, tbl[i].ed);
      check($sformatf("vec%0d in_ready", i), s_ready, tbl[i].er);
    end

    // Reset mid-operation while the skid variant holds two entries.
    step(1, 8'h91, 32'h91, 0, 0);
    step(1, 8'h92, 32'h92, 0, 0);
    #1;
    check("hold2 skid out_ctrl", s_ctrl, 8'h91);
    check("hold2 skid in_ready", s_ready, 0);
    do_reset();

    // Register variant: out_ready toggling with in_valid held high.
    for (int i = 0; i < 8; i++) begin
      step(1, 8'h80 + 8'(i), 32'(i) + 32'h1000, (i % 2) == 0, 0);
    end
    step(0, 8'h00, 32'h0, 1, 0);
    step(0, 8'h00, 32'h0, 1, 0);

    // Bubble counter saturation on the 3-bit instance.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(0, 8'h00, 32'h0, 1, 0);
      #1;
      check($sformatf("sat edge%0d bubble_cnt", i), c_cnt, (i < 7) ? i : 7);
    end

    // Randomized traffic with varying downstream back-pressure.
    pct = 90;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        case ((i / 500) % 3)
          0:       pct = 90;
          1:       pct = 50;
          default: pct = 20;
        endcase
      end
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom,
           $urandom_range(0, 99) < pct, $urandom_range(0, 31) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
